// File: rtl/stream_serializer_if.sv
// Bundles the hypervector input strobe and the valid/ready beat output of the
// stream serializer so both ends share a single port.
interface stream_serializer_if #(
    parameter int DIM   = 1023,
    parameter int OUT_W = 64
);
    logic             stream_v;
    logic [DIM:0]     stream_d;
    logic             stream_last;
    logic             dst_valid;
    logic [OUT_W-1:0] dst_data;
    logic             dst_last;
    logic             dst_ready;

    // Producer/consumer side: feeds hypervectors, accepts beats.
    modport master (
        output stream_v, stream_d, stream_last, dst_ready,
        input  dst_valid, dst_data, dst_last
    );

    // Serializer side.
    modport slave (
        input  stream_v, stream_d, stream_last, dst_ready,
        output dst_valid, dst_data, dst_last
    );
endinterface

// File: rtl/stream_serializer.sv
// Buffers up to DEPTH whole hypervectors and emits each one as BEATS
// OUT_W-bit beats, LSB word first, with an end-of-job tag and sticky overflow.
module stream_serializer #(
    parameter int DIM   = 1023,
    parameter int OUT_W = 64,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    stream_serializer_if.slave bus,
    output logic              overflow,
    output logic              busy,
    output logic [15:0]       hv_sent
);
    localparam int BEATS  = (DIM + 1) / OUT_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

    typedef struct packed {
        logic                        last;
        logic [BEATS-1:0][OUT_W-1:0] words;
    } entry_t;

    entry_t            r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [BEAT_W-1:0] r_beat;
    logic              r_overflow;
    logic [15:0]       r_hv_sent;

    entry_t w_head;
    logic   w_valid;
    logic   w_xfer;
    logic   w_pop;
    logic   w_space;
    logic   w_push;

    assign w_head  = r_mem[r_rd_ptr];
    assign w_valid = (r_count != '0);
    assign w_xfer  = w_valid & bus.dst_ready;
    assign w_pop   = w_xfer & (r_beat == LAST_BEAT);
    // A full FIFO still has room when its head leaves on this same edge.
    assign w_space = (r_count != FULL_CNT) | w_pop;
    assign w_push  = bus.stream_v & w_space;

    // Every output is a function of registered state only.
    assign bus.dst_valid = w_valid;
    assign bus.dst_data  = w_head.words[r_beat];
    assign bus.dst_last  = w_valid & (r_beat == LAST_BEAT) & w_head.last;
    assign busy          = w_valid;
    assign overflow      = r_overflow;
    assign hv_sent       = r_hv_sent;

    // NOTE: storage is deliberately left out of reset; the zeroed count marks
    // every slot empty, so stale contents are never presented.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{last: bus.stream_last, words: bus.stream_d};
        end
    end

    // NOTE: all state here is updated with <= so every term on the right
    // sees the value from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_beat     <= '0;
            r_overflow <= 1'b0;
            r_hv_sent  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end

            if (bus.stream_v && !w_space) begin
                r_overflow <= 1'b1;
            end

            if (w_xfer) begin
                if (r_beat == LAST_BEAT) begin
                    r_beat    <= '0;
                    r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
                    r_hv_sent <= r_hv_sent + 16'd1;
                end else begin
                    r_beat <= r_beat + BEAT_W'(1);
                end
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
